branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush is held after a redirect (range 0..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port br_valid, input, 1, meaning a branch/jump request is presented.
REQ-005 SHALL have port br_ready, output, 1, meaning a request is accepted this cycle.
REQ-006 SHALL have port br_jump, input, 1, meaning an unconditional jump with no compare.
REQ-007 SHALL have port br_funct3, input, 3, the RISC-V branch funct3.
REQ-008 SHALL have ports br_rs1_d, br_rs2_d, br_pc and br_imm, each input, 32, carrying the operands, the branch PC and the sign-extended offset.
REQ-009 SHALL have ports cmp_rs1_d and cmp_rs2_d (output, 32), cmp_op (output, 3) and cmp_b (input, 1), connecting to the shared cmp comparator.
REQ-010 SHALL have ports resolve_valid and resolve_taken, each output, 1, giving the conditional-branch outcome.
REQ-011 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, 32), the fetch redirect.
REQ-012 SHALL have port flush, output, 1, which squashes younger pipeline stages.
REQ-013 SHALL have ports illegal and misaligned, each output, 1, which are one-cycle exception pulses.
REQ-014 SHALL have port taken_cnt, output, 16, counting redirects taken.

Function
REQ-015 SHALL implement the FSM states IDLE, EVAL, REDIRECT and FLUSH.
REQ-016 SHALL assert br_ready only in IDLE; a request is accepted when br_valid and br_ready are both 1.
REQ-017 On accept, SHALL register funct3, rs1, rs2 and target = br_pc + br_imm, with the sum taken mod 2^32.
REQ-018 On accept:
- jump -> REDIRECT;
- funct3 in {010, 011} without jump -> illegal pulses for 1 cycle, state stays IDLE;
- otherwise -> EVAL.
REQ-019 In EVAL, SHALL drive cmp_rs1_d, cmp_rs2_d and cmp_op from the registered values, and assert resolve_valid=1 with resolve_taken=cmp_b.
REQ-020 EVAL transitions:
- cmp_b=1 -> REDIRECT;
- cmp_b=0 -> IDLE.
REQ-021 Outside EVAL, cmp_op SHALL be 000, cmp operands SHALL be 0, and resolve_valid SHALL be 0.
REQ-022 In REDIRECT, if target[1:0]==00, SHALL assert redirect_valid=1 for exactly 1 cycle with redirect_pc=target and increment taken_cnt.
REQ-023 In REDIRECT, if target[1:0]!=00, SHALL pulse misaligned, assert no redirect, not increment taken_cnt, and go to IDLE.
REQ-024 After a valid redirect, SHALL go to FLUSH with the counter loaded to FLUSH_CYCLES; if FLUSH_CYCLES==0, it goes to IDLE instead.
REQ-025 In FLUSH, SHALL hold flush=1 and decrement the counter each cycle, returning to IDLE on the cycle the counter reaches 1.
REQ-026 taken_cnt SHALL saturate at 16'hFFFF.
REQ-027 Latencies from the accept cycle N:
- not-taken branch: resolve in cycle N+1, br_ready again in N+2;
- taken branch: redirect in N+2;
- jump: redirect in N+1.
REQ-028 br_valid outside IDLE SHALL be ignored; the requester holds it until br_ready.

Reset
REQ-029 While rst_n=0, SHALL force:
- state IDLE, counters 0, taken_cnt 0;
- all registered data 0;
- redirect_valid, flush, illegal, misaligned and resolve_valid all 0.
REQ-030 Reset asserted mid-operation (EVAL, REDIRECT or FLUSH) SHALL abort immediately with no redirect or flush after release; br_ready=1 the first cycle after deassertion.

Structure
REQ-031 SHALL take the funct3 encodings (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111) and the state typedef from shared package core_pkg.
REQ-032 SHALL instantiate no comparator; cmp remains a separate shared instance, and a small flush down-counter sub-module flush_cnt is natural.

Verification
REQ-033 BEQ with rs1=10, rs2=10, pc=0x100, imm=0x20 -> resolve_taken=1, redirect_pc=0x120 at N+2, flush high 2 cycles, taken_cnt=1.
REQ-034 BLT with rs1=-4, rs2=3 -> taken; BLTU with the same operands -> not taken, no redirect, br_ready at N+2.
REQ-035 br_jump=1, pc=0x200, imm=-8 -> redirect_pc=0x1F8 at N+1, no resolve_valid; funct3=010 without jump -> illegal pulse, state stays IDLE.
REQ-036 Taken BNE with pc=0x100, imm=0x2 -> misaligned pulse, no redirect_valid, taken_cnt unchanged.
REQ-037 rst_n low during FLUSH -> flush=0 immediately, br_ready=1 after release; taken_cnt preloaded to 0xFFFF plus a taken branch -> stays 0xFFFF.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_pkg
// Brief   : Shared branch funct3 encodings and branch-controller state type.
// Revision: 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [2:0] c_f3_beq  = 3'b000;
    localparam logic [2:0] c_f3_bne  = 3'b001;
    localparam logic [2:0] c_f3_blt  = 3'b100;
    localparam logic [2:0] c_f3_bge  = 3'b101;
    localparam logic [2:0] c_f3_bltu = 3'b110;
    localparam logic [2:0] c_f3_bgeu = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } br_state_e;

    // Only the six conditional-branch encodings are legal without a jump.
    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return !(f3 inside {c_f3_beq, c_f3_bne, c_f3_blt,
                            c_f3_bge, c_f3_bltu, c_f3_bgeu});
    endfunction

endpackage
`default_nettype wire

// File: rtl/flush_cnt.sv
`default_nettype none
// ============================================================================
// Module  : flush_cnt
// Brief   : Loadable 4-bit down-counter timing the post-redirect flush window.
// Revision: 1.0 - initial release
// ============================================================================
module flush_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_last
);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_last = (r_count == 4'd1);

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : branch_ctrl
// Brief   : Branch/jump resolution FSM driving a shared comparator, fetch
//           redirect, flush window and taken-redirect counter.
// Revision: 1.0 - initial release
// ============================================================================
module branch_ctrl
    import core_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic        br_jump,
    input  logic [2:0]  br_funct3,
    input  logic [31:0] br_rs1_d,
    input  logic [31:0] br_rs2_d,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    output logic [31:0] cmp_rs1_d,
    output logic [31:0] cmp_rs2_d,
    output logic [2:0]  cmp_op,
    input  logic        cmp_b,
    output logic        resolve_valid,
    output logic        resolve_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        illegal,
    output logic        misaligned,
    output logic [15:0] taken_cnt
);

    localparam logic [3:0] c_flush_init = 4'(FLUSH_CYCLES);

    br_state_e   r_state;
    logic [2:0]  r_funct3;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_target;
    logic        r_illegal;
    logic [15:0] r_taken_cnt;

    logic w_accept;
    logic w_in_eval;
    logic w_in_redirect;
    logic w_aligned;
    logic w_redirect_ok;
    logic w_flush_last;

    assign w_accept      = br_valid && br_ready;
    assign w_in_eval     = (r_state == ST_EVAL);
    assign w_in_redirect = (r_state == ST_REDIRECT);
    assign w_aligned     = (r_target[1:0] == 2'b00);
    assign w_redirect_ok = w_in_redirect && w_aligned;

    flush_cnt u_flush_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_redirect_ok),
        .i_load_val (c_flush_init),
        .i_dec      (r_state == ST_FLUSH),
        .o_last     (w_flush_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_funct3    <= 3'd0;
            r_rs1       <= 32'd0;
            r_rs2       <= 32'd0;
            r_target    <= 32'd0;
            r_illegal   <= 1'b0;
            r_taken_cnt <= 16'd0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= br_funct3;
                        r_rs1    <= br_rs1_d;
                        r_rs2    <= br_rs2_d;
                        r_target <= br_pc + br_imm;
                        if (br_jump) begin
                            r_state <= ST_REDIRECT;
                        end else if (is_illegal_f3(br_funct3)) begin
                            r_illegal <= 1'b1;
                        end else begin
                            r_state <= ST_EVAL;
                        end
                    end
                end
                ST_EVAL: begin
                    r_state <= cmp_b ? ST_REDIRECT : ST_IDLE;
                end
                ST_REDIRECT: begin
                    // A misaligned target is reported instead of redirecting.
                    if (w_aligned) begin
                        if (r_taken_cnt != 16'hFFFF) begin
                            r_taken_cnt <= r_taken_cnt + 16'd1;
                        end
                        r_state <= (FLUSH_CYCLES == 0) ? ST_IDLE : ST_FLUSH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign br_ready       = (r_state == ST_IDLE);
    assign cmp_op         = w_in_eval ? r_funct3 : 3'b000;
    assign cmp_rs1_d      = w_in_eval ? r_rs1 : 32'd0;
    assign cmp_rs2_d      = w_in_eval ? r_rs2 : 32'd0;
    assign resolve_valid  = w_in_eval;
    assign resolve_taken  = w_in_eval && cmp_b;
    assign redirect_valid = w_redirect_ok;
    assign redirect_pc    = w_redirect_ok ? r_target : 32'd0;
    assign flush          = (r_state == ST_FLUSH);
    assign illegal        = r_illegal;
    assign misaligned     = w_in_redirect && !w_aligned;
    assign taken_cnt      = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_ctrl
// Brief   : Self-checking bench for branch_ctrl with a cycle-timeline model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

    localparam int FC = 2;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic        br_jump;
    logic [2:0]  br_funct3;
    logic [31:0] br_rs1_d;
    logic [31:0] br_rs2_d;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic [31:0] cmp_rs1_d;
    logic [31:0] cmp_rs2_d;
    logic [2:0]  cmp_op;
    logic        cmp_b;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        illegal;
    logic        misaligned;
    logic [15:0] taken_cnt;

    int          n_assert;
    int          n_fail;
    logic [15:0] model_cnt;

    typedef struct {
        logic        ready;
        logic        rv;
        logic        rt;
        logic        rdv;
        logic [31:0] rpc;
        logic        fl;
        logic        ill;
        logic        mis;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_jump        (br_jump),
        .br_funct3      (br_funct3),
        .br_rs1_d       (br_rs1_d),
        .br_rs2_d       (br_rs2_d),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .cmp_rs1_d      (cmp_rs1_d),
        .cmp_rs2_d      (cmp_rs2_d),
        .cmp_op         (cmp_op),
        .cmp_b          (cmp_b),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .illegal        (illegal),
        .misaligned     (misaligned),
        .taken_cnt      (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V branch condition; also serves as the shared comparator model.
    function automatic logic br_cond(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb cmp_b = br_cond(cmp_op, cmp_rs1_d, cmp_rs2_d);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e = '{ready: 1'b1, rv: 1'b0, rt: 1'b0, rdv: 1'b0, rpc: 32'd0, fl: 1'b0,
              ill: 1'b0, mis: 1'b0, op: 3'd0, a: 32'd0, b: 32'd0};
        return e;
    endfunction

    task automatic chk_cycle(input exp_t e);
        chk("br_ready", br_ready, e.ready);
        chk("resolve_valid", resolve_valid, e.rv);
        if (e.rv) chk("resolve_taken", resolve_taken, e.rt);
        chk("redirect_valid", redirect_valid, e.rdv);
        if (e.rdv) chk("redirect_pc", redirect_pc, e.rpc);
        chk("flush", flush, e.fl);
        chk("illegal", illegal, e.ill);
        chk("misaligned", misaligned, e.mis);
        chk("cmp_op", cmp_op, e.op);
        chk("cmp_rs1_d", cmp_rs1_d, e.a);
        chk("cmp_rs2_d", cmp_rs2_d, e.b);
    endtask

    // Presents one request, then checks every cycle until the controller idles.
    task automatic run_txn(input logic jump, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm);
        exp_t        q[$];
        exp_t        e;
        logic [31:0] tgt;
        logic        go;
        int          waited;
        waited = 0;
        while (br_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_accept", br_ready, 1'b1);
        br_valid  = 1'b1;
        br_jump   = jump;
        br_funct3 = f3;
        br_rs1_d  = rs1;
        br_rs2_d  = rs2;
        br_pc     = pc;
        br_imm    = imm;

        tgt = pc + imm;
        go  = jump;
        if (!jump && (f3 == 3'b010 || f3 == 3'b011)) begin
            e = idle_e(); e.ill = 1'b1; q.push_back(e);
        end else if (!jump) begin
            e = idle_e(); e.ready = 1'b0; e.rv = 1'b1; e.rt = br_cond(f3, rs1, rs2);
            e.op = f3; e.a = rs1; e.b = rs2;
            q.push_back(e);
            go = e.rt;
        end
        if (go) begin
            e = idle_e(); e.ready = 1'b0;
            if (tgt[1:0] == 2'b00) begin
                e.rdv = 1'b1; e.rpc = tgt; q.push_back(e);
                for (int k = 0; k < FC; k++) begin
                    e = idle_e(); e.ready = 1'b0; e.fl = 1'b1; q.push_back(e);
                end
                model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
            end else begin
                e.mis = 1'b1; q.push_back(e);
            end
        end
        q.push_back(idle_e());

        @(negedge clk);
        br_valid = 1'b0;
        br_rs1_d = $urandom;
        br_rs2_d = $urandom;
        br_pc    = $urandom;
        br_imm   = $urandom;
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) @(negedge clk);
            chk_cycle(q[i]);
        end
        chk("taken_cnt", taken_cnt, model_cnt);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] imm;
        n_assert  = 0;
        n_fail    = 0;
        model_cnt = 16'd0;
        rst_n     = 1'b0;
        br_valid  = 1'b0;
        br_jump   = 1'b0;
        br_funct3 = 3'd0;
        br_rs1_d  = 32'd0;
        br_rs2_d  = 32'd0;
        br_pc     = 32'd0;
        br_imm    = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_misaligned", misaligned, 1'b0);
        chk("rst_resolve_valid", resolve_valid, 1'b0);
        chk("rst_taken_cnt", taken_cnt, 16'd0);
        chk("rst_cmp_op", cmp_op, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", br_ready, 1'b1);

        // Directed cases
        run_txn(1'b0, 3'b000, 32'd10, 32'd10, 32'h100, 32'h20);
        run_txn(1'b0, 3'b100, 32'hFFFF_FFFC, 32'd3, 32'h100, 32'h40);
        run_txn(1'b0, 3'b110, 32'hFFFF_FFFC, 32'd3, 32'h100, 32'h40);
        run_txn(1'b1, 3'b000, 32'd0, 32'd0, 32'h200, 32'hFFFF_FFF8);
        run_txn(1'b0, 3'b010, 32'd1, 32'd2, 32'h300, 32'h4);
        run_txn(1'b0, 3'b011, 32'd1, 32'd1, 32'h300, 32'h4);
        run_txn(1'b0, 3'b001, 32'd1, 32'd2, 32'h100, 32'h2);
        run_txn(1'b1, 3'b010, 32'd0, 32'd0, 32'h201, 32'h0);
        run_txn(1'b0, 3'b101, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h20);
        run_txn(1'b0, 3'b111, 32'd3, 32'hFFFF_FFFC, 32'h500, 32'h8);

        // Randomized requests
        for (int n = 0; n < 60; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
            b  = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom
                                                    : 32'($urandom_range(0, 8)) - 32'd4);
            r  = $urandom;
            imm = {{20{r[11]}}, r[11:0]};
            if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
            run_txn(($urandom_range(0, 3) == 0), f3, a, b, {r[31:14], 14'd0}, imm);
        end

        // Reset while flushing aborts without later redirect or flush
        br_valid = 1'b1; br_jump = 1'b1; br_funct3 = 3'd0; br_pc = 32'h300; br_imm = 32'd0;
        @(negedge clk);
        br_valid = 1'b0;
        chk("abort_redirect", redirect_valid, 1'b1);
        @(negedge clk);
        chk("abort_flush_before", flush, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_flush_async", flush, 1'b0);
        chk("abort_taken_cnt", taken_cnt, 16'd0);
        model_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", br_ready, 1'b1);
        chk("abort_no_flush", flush, 1'b0);
        chk("abort_no_redirect", redirect_valid, 1'b0);
        @(negedge clk);
        chk("abort_no_flush2", flush, 1'b0);

        // Saturation of the taken counter
        force dut.r_taken_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_taken_cnt;
        @(negedge clk);
        chk("sat_preload", taken_cnt, 16'hFFFF);
        model_cnt = 16'hFFFF;
        run_txn(1'b0, 3'b000, 32'd5, 32'd5, 32'h400, 32'h10);
        run_txn(1'b1, 3'b000, 32'd0, 32'd0, 32'h800, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
